// File: rtl/led_pattern_sequencer_if.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer_if
//
// Purpose : TinyTapeout-style I/O bundle for the LED pattern sequencer.
//           The user module sees every pin, including its clock and reset,
//           through this 8-in / 8-out pair.
//
// Signals : io_in[0]   clock, rising edge
//           io_in[1]   reset, synchronous, active-high
//           io_in[2]   run (1 = prescaler counts)
//           io_in[3]   advance (rising edge forces the next mode)
//           io_in[5:4] speed select 0..3
//           io_in[6]   auto (automatic mode cycling)
//           io_in[7]   reverse (direction for CHASE and FILL)
//           io_out[7:0] LED pattern
//
// Modports: master drives io_in (board / testbench side)
//           slave  drives io_out (the user module)
// -----------------------------------------------------------------------------
interface led_pattern_sequencer_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface : led_pattern_sequencer_if

// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer
//
// Purpose : Drives 8 LEDs from an internal pattern register that steps
//           through four modes (CHASE, FILL, BOUNCE, LFSR). A programmable
//           prescaler sets the step rate; modes change on a rising edge of
//           the advance pin or after STEPS_PER_MODE ticks when auto is set.
//
// Ports   : tt_io (slave modport of led_pattern_sequencer_if)
//             io_in[0] clock, io_in[1] synchronous active-high reset,
//             io_in[7:2] control pins, io_out[7:0] LED pattern.
//
// Params  : SPEED_BASE     log2 of the step period at speed 0;
//                          period = 2^(SPEED_BASE + 2*speed) clocks
//           PRESCALE_W     prescaler width, >= SPEED_BASE+6
//           STEPS_PER_MODE ticks per mode before an automatic change
// -----------------------------------------------------------------------------
module led_pattern_sequencer #(
  parameter int SPEED_BASE     = 2,
  parameter int PRESCALE_W     = 10,
  parameter int STEPS_PER_MODE = 16
) (
  led_pattern_sequencer_if.slave tt_io
);

  localparam int SC_W = (STEPS_PER_MODE > 1) ? $clog2(STEPS_PER_MODE) : 1;
  localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEPS_PER_MODE - 1);

  localparam logic [7:0] ENTRY_CHASE  = 8'h01;
  localparam logic [7:0] ENTRY_FILL   = 8'h00;
  localparam logic [7:0] ENTRY_BOUNCE = 8'h01;
  localparam logic [7:0] ENTRY_LFSR   = 8'hE1;

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'd0,
    MODE_FILL   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_LFSR   = 2'd3
  } mode_e;

  logic clk;
  logic rst;

  assign clk = tt_io.io_in[0];
  assign rst = tt_io.io_in[1];

  // ---------------------------------------------------------------------------
  // Input synchronizers: io_in[7:2] -> two flops each; advance gets a third
  // flop so a held pin produces a single one-cycle pulse.
  // ---------------------------------------------------------------------------
  logic [5:0] sync1_q;
  logic [5:0] sync2_q;
  logic       adv_prev_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours (the synchronizer chain
  // would collapse into a single flop with blocking assignments).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      adv_prev_q <= 1'b0;
    end else begin
      sync1_q    <= tt_io.io_in[7:2];
      sync2_q    <= sync1_q;
      adv_prev_q <= sync2_q[1];
    end
  end

  logic       run_s;
  logic       adv_s;
  logic [1:0] speed_s;
  logic       auto_s;
  logic       rev_s;

  assign run_s   = sync2_q[0];
  assign adv_s   = sync2_q[1];
  assign speed_s = sync2_q[3:2];
  assign auto_s  = sync2_q[4];
  assign rev_s   = sync2_q[5];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mode_e                 mode_q,    mode_d;
  logic [7:0]            pattern_q, pattern_d;
  logic [PRESCALE_W-1:0] count_q,   count_d;
  logic [SC_W-1:0]       step_q,    step_d;
  logic                  bdir_q,    bdir_d;

  logic [PRESCALE_W-1:0] period_m1;
  logic                  tick;
  logic                  adv_pulse;
  logic                  mode_change;

  // Terminal count P-1. ">=" rather than "==" so that dropping the speed
  // while the counter is already past the new limit ticks at once instead
  // of wrapping the whole counter.
  assign period_m1 = (PRESCALE_W'(1) << (SPEED_BASE + 2 * int'(speed_s)))
                     - PRESCALE_W'(1);
  assign tick      = run_s && (count_q >= period_m1);
  assign adv_pulse = adv_s && !adv_prev_q;

  // An advance pulse coinciding with a tick is a single mode change; the
  // step that tick would have made is dropped.
  assign mode_change = adv_pulse || (tick && auto_s && (step_q == STEP_LAST));

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_CHASE:  return MODE_FILL;
      MODE_FILL:   return MODE_BOUNCE;
      MODE_BOUNCE: return MODE_LFSR;
      default:     return MODE_CHASE;
    endcase
  endfunction

  function automatic logic [7:0] entry_pattern(input mode_e m);
    case (m)
      MODE_CHASE:  return ENTRY_CHASE;
      MODE_FILL:   return ENTRY_FILL;
      MODE_BOUNCE: return ENTRY_BOUNCE;
      default:     return ENTRY_LFSR;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every _d signal is given its hold value first, so no path through
  // the branches below leaves a signal unassigned and no latch is inferred.
  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern_q;
    count_d   = count_q;
    step_d    = step_q;
    bdir_d    = bdir_q;

    if (mode_change) begin
      mode_d    = next_mode(mode_q);
      pattern_d = entry_pattern(next_mode(mode_q));
      count_d   = '0;
      step_d    = '0;
      bdir_d    = 1'b0;
    end else if (tick) begin
      count_d = '0;
      // Saturates when auto is off; with auto on the last value always
      // coincides with a mode change, which takes the branch above.
      step_d  = (step_q == STEP_LAST) ? step_q : step_q + SC_W'(1);

      case (mode_q)
        MODE_CHASE: begin
          pattern_d = rev_s ? {pattern_q[0], pattern_q[7:1]}
                            : {pattern_q[6:0], pattern_q[7]};
        end
        MODE_FILL: begin
          // Johnson counter: the inverted end bit is fed back, period 16.
          pattern_d = rev_s ? {~pattern_q[0], pattern_q[7:1]}
                            : {pattern_q[6:0], ~pattern_q[7]};
        end
        MODE_BOUNCE: begin
          // Direction flips on the tick that reaches an end LED, and that
          // same tick already moves one position back.
          if (!bdir_q) begin
            if (pattern_q[7]) begin
              bdir_d    = 1'b1;
              pattern_d = pattern_q >> 1;
            end else begin
              pattern_d = pattern_q << 1;
            end
          end else begin
            if (pattern_q[0]) begin
              bdir_d    = 1'b0;
              pattern_d = pattern_q << 1;
            end else begin
              pattern_d = pattern_q >> 1;
            end
          end
        end
        default: begin
          // Maximal-length taps 8,6,5,4. All-zero is a lock-up state, so
          // reseed if it is ever reached.
          if (pattern_q == 8'h00) begin
            pattern_d = ENTRY_LFSR;
          end else begin
            pattern_d = {pattern_q[6:0],
                         pattern_q[7] ^ pattern_q[5] ^ pattern_q[4] ^ pattern_q[3]};
          end
        end
      endcase
    end else if (run_s) begin
      count_d = count_q + PRESCALE_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_CHASE;
      pattern_q <= ENTRY_CHASE;
      count_q   <= '0;
      step_q    <= '0;
      bdir_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      count_q   <= count_d;
      step_q    <= step_d;
      bdir_q    <= bdir_d;
    end
  end

  assign tt_io.io_out = pattern_q;

endmodule : led_pattern_sequencer

// File: tb/tb_led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_sequencer
//
// Directed scenarios followed by a randomized run compared cycle by cycle
// against a position-based reference model of the sequencer.
// -----------------------------------------------------------------------------
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       adv = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       auto_en = 1'b0;
  logic       rev = 1'b0;

  int total = 0;
  int bad   = 0;

  led_pattern_sequencer_if bus ();

  assign bus.io_in = {rev, auto_en, speed, adv, run, rst, clk};

  led_pattern_sequencer dut (.tt_io(bus));

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: each mode is a position on its own cycle of patterns
  // (CHASE 8, FILL 16, BOUNCE 14) or the LFSR value itself. Pin values are
  // seen two edges late; advance acts on a 0->1 change of that late copy.
  // ---------------------------------------------------------------------------
  int         m_mode = 0;
  int         m_pos = 0;
  int         m_cnt = 0;
  int         m_steps = 0;
  logic [7:0] m_lfsr = 8'hE1;
  logic [5:0] h1 = '0, h2 = '0, h3 = '0;
  int         m_period;
  bit         m_tick, m_chg;

  function automatic logic [7:0] fill_pat(input int j);
    logic [7:0] ones;
    ones = 8'hFF;
    if (j < 8) return 8'((1 << j) - 1);
    return ones << (j - 8);
  endfunction

  function automatic logic [7:0] bounce_pat(input int j);
    if (j <= 7) return 8'(1 << j);
    return 8'(1 << (14 - j));
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] p);
    if (p == 8'h00) return 8'hE1;
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
  endfunction

  function automatic logic [7:0] model_pattern();
    case (m_mode)
      0:       return 8'(1 << m_pos);
      1:       return fill_pat(m_pos);
      2:       return bounce_pat(m_pos);
      default: return m_lfsr;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_pos = 0; m_cnt = 0; m_steps = 0; m_lfsr = 8'hE1;
      h1 = '0; h2 = '0; h3 = '0;
    end else begin
      m_period = 1 << (2 + 2 * int'(h2[3:2]));
      m_tick   = h2[0] && (m_cnt >= m_period - 1);
      m_chg    = (h2[1] && !h3[1]) || (m_tick && h2[4] && m_steps == 15);
      if (m_chg) begin
        m_mode = (m_mode + 1) % 4;
        m_pos = 0; m_lfsr = 8'hE1; m_cnt = 0; m_steps = 0;
      end else if (m_tick) begin
        m_cnt = 0;
        if (m_steps < 15) m_steps++;
        case (m_mode)
          0:       m_pos = h2[5] ? (m_pos + 7) % 8 : (m_pos + 1) % 8;
          1:       m_pos = h2[5] ? (m_pos + 15) % 16 : (m_pos + 1) % 16;
          2:       m_pos = (m_pos + 1) % 14;
          default: m_lfsr = lfsr_next(m_lfsr);
        endcase
      end else if (h2[0]) begin
        m_cnt++;
      end
      h3 = h2; h2 = h1; h1 = {rev, auto_en, speed, adv, run};
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive only)
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic r, input logic [1:0] s,
                          input logic a, input logic v);
    rst = 1'b1; run = r; speed = s; auto_en = a; rev = v; adv = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic pulse_advance();
    adv = 1'b1;
    step(2);
    adv = 1'b0;
    step(4);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; run = 1'b0; adv = 1'b0; speed = 2'd0; auto_en = 1'b0; rev = 1'b0;
    step(2);
    total++;
    if (bus.io_out !== 8'h01) begin
      bad++;
      $display("FAIL reset_value: got %h want 01", bus.io_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_chase();
    logic [7:0] exp;
    do_reset(1'b1, 2'd0, 1'b0, 1'b0);
    for (int n = 1; n <= 38; n++) begin
      step(1);
      exp = (n < 6) ? 8'h01 : 8'(1 << (((n - 2) / 4) % 8));
      total++;
      if (bus.io_out !== exp) begin
        bad++;
        $display("FAIL chase edge %0d: got %h want %h", n, bus.io_out, exp);
      end
    end
  endtask

  task automatic test_auto();
    logic [7:0] exp;
    do_reset(1'b1, 2'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      step(k == 1 ? 6 : 4);
      if (k <= 15)      exp = 8'(1 << (k % 8));
      else if (k == 16) exp = 8'h00;
      else              exp = fill_pat(k - 16);
      total++;
      if (bus.io_out !== exp) begin
        bad++;
        $display("FAIL auto tick %0d: got %h want %h", k, bus.io_out, exp);
      end
    end
  endtask

  task automatic test_advance_paused();
    do_reset(1'b0, 2'd0, 1'b0, 1'b0);
    step(3);
    adv = 1'b1;
    step(2);
    total++;
    if (bus.io_out !== 8'h01) begin
      bad++;
      $display("FAIL adv_early: got %h want 01", bus.io_out);
    end
    adv = 1'b0;
    step(1);
    total++;
    if (bus.io_out !== 8'h00) begin
      bad++;
      $display("FAIL adv_to_fill: got %h want 00", bus.io_out);
    end
    step(10);
    total++;
    if (bus.io_out !== 8'h00) begin
      bad++;
      $display("FAIL adv_frozen: got %h want 00", bus.io_out);
    end
    adv = 1'b1;
    step(2);
    adv = 1'b0;
    step(1);
    total++;
    if (bus.io_out !== 8'h01) begin
      bad++;
      $display("FAIL adv_to_bounce: got %h want 01", bus.io_out);
    end
  endtask

  // Continues from BOUNCE at 01 with the prescaler cleared.
  task automatic test_bounce();
    logic [7:0] exp;
    step(3);
    rev = 1'b1;
    run = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(k == 1 ? 6 : 4);
      exp = bounce_pat(k % 14);
      total++;
      if (bus.io_out !== exp) begin
        bad++;
        $display("FAIL bounce tick %0d: got %h want %h", k, bus.io_out, exp);
      end
    end
    rev = 1'b0;
  endtask

  // Continues from BOUNCE; pauses, advances into LFSR, then runs a full cycle.
  task automatic test_lfsr();
    logic [7:0] first3 [3];
    bit         saw_zero;
    first3[0] = 8'hC2; first3[1] = 8'h85; first3[2] = 8'h0B;
    saw_zero = 1'b0;
    run = 1'b0;
    step(4);
    pulse_advance();
    total++;
    if (bus.io_out !== 8'hE1) begin
      bad++;
      $display("FAIL lfsr_entry: got %h want e1", bus.io_out);
    end
    run = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      step(k == 1 ? 6 : 4);
      if (bus.io_out === 8'h00) saw_zero = 1'b1;
      if (k <= 3) begin
        total++;
        if (bus.io_out !== first3[k-1]) begin
          bad++;
          $display("FAIL lfsr tick %0d: got %h want %h", k, bus.io_out, first3[k-1]);
        end
      end
    end
    total++;
    if (bus.io_out !== 8'hE1) begin
      bad++;
      $display("FAIL lfsr_period: got %h want e1", bus.io_out);
    end
    total++;
    if (saw_zero !== 1'b0) begin
      bad++;
      $display("FAIL lfsr_nonzero: saw_zero=%0d want 0", saw_zero);
    end
  endtask

  // Continues from LFSR; walks to FILL, steps to 0F, resets mid-count.
  task automatic test_reset_mid();
    run = 1'b0;
    step(4);
    pulse_advance();
    pulse_advance();
    total++;
    if (bus.io_out !== 8'h00) begin
      bad++;
      $display("FAIL mid_fill_entry: got %h want 00", bus.io_out);
    end
    run = 1'b1;
    step(18);
    total++;
    if (bus.io_out !== 8'h0F) begin
      bad++;
      $display("FAIL mid_fill_0f: got %h want 0f", bus.io_out);
    end
    step(2);
    rst = 1'b1;
    step(1);
    total++;
    if (bus.io_out !== 8'h01) begin
      bad++;
      $display("FAIL mid_reset: got %h want 01", bus.io_out);
    end
    rst = 1'b0;
    step(5);
    total++;
    if (bus.io_out !== 8'h01) begin
      bad++;
      $display("FAIL mid_no_early_tick: got %h want 01", bus.io_out);
    end
    step(1);
    total++;
    if (bus.io_out !== 8'h02) begin
      bad++;
      $display("FAIL mid_first_tick: got %h want 02", bus.io_out);
    end
    step(4);
    total++;
    if (bus.io_out !== 8'h04) begin
      bad++;
      $display("FAIL mid_chase_next: got %h want 04", bus.io_out);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    int         shown;
    shown = 0;
    do_reset(1'b1, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      exp = model_pattern();
      total++;
      if (bus.io_out !== exp) begin
        bad++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cycle %0d: got %h want %h", i, bus.io_out, exp);
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 59) == 0)
        speed = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      if ($urandom_range(0, 99) == 0) run = ~run;
      if ($urandom_range(0, 79) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 19) == 0) rev = ~rev;
      if ($urandom_range(0, 29) == 0) adv = ~adv;
      step(1);
    end
    rst = 1'b0;
  endtask

  initial begin
    step(1);
    test_reset();
    test_chase();
    test_auto();
    test_advance_paused();
    test_bounce();
    test_lfsr();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_led_pattern_sequencer
